// File: rtl/alu_pkg.sv
// Shared ALU control encodings, FSM state type and the reference decode table.
package alu_pkg;

   localparam int unsigned ALUOP_W   = 2;
   localparam int unsigned FUNCT_B_W = 4;
   localparam int unsigned OPC_B_W   = 3;
   localparam int unsigned OP_B_W    = 4;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [ALUOP_W-1:0] ALUOP_ITYPE = 2'b11;

   localparam logic [FUNCT_B_W-1:0] FUNCT_XOR = 4'b1101;
   localparam logic [FUNCT_B_W-1:0] FUNCT_ADD = 4'b0000;
   localparam logic [FUNCT_B_W-1:0] FUNCT_SUB = 4'b0001;
   localparam logic [FUNCT_B_W-1:0] FUNCT_MOD = 4'b0010;

   localparam logic [OPC_B_W-1:0] OPC_SLTI = 3'b100;
   localparam logic [OPC_B_W-1:0] OPC_ADDI = 3'b011;
   localparam logic [OPC_B_W-1:0] OPC_ORI  = 3'b010;
   localparam logic [OPC_B_W-1:0] OPC_ANDI = 3'b001;

   localparam logic [OP_B_W-1:0] OP_ADD  = 4'b0100;
   localparam logic [OP_B_W-1:0] OP_SUB  = 4'b1100;
   localparam logic [OP_B_W-1:0] OP_XOR  = 4'b0011;
   localparam logic [OP_B_W-1:0] OP_MOD  = 4'b0111;
   localparam logic [OP_B_W-1:0] OP_SLTI = 4'b0001;
   localparam logic [OP_B_W-1:0] OP_ADDI = 4'b0101;
   localparam logic [OP_B_W-1:0] OP_ORI  = 4'b0010;
   localparam logic [OP_B_W-1:0] OP_ANDI = 4'b0000;

   localparam logic [OP_B_W-1:0] NOP_CODE = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      VALID = 2'd2
   } state_e;

   typedef struct packed {
      logic              illegal;
      logic [OP_B_W-1:0] op;
   } dec_t;

   // Base-width table; callers handle any widened-field upper bits themselves.
   function automatic dec_t alu_decode(input logic [ALUOP_W-1:0]   aluop,
                                       input logic [FUNCT_B_W-1:0] funct,
                                       input logic [OPC_B_W-1:0]   opcode);
      dec_t d;
      d.illegal = 1'b0;
      d.op      = NOP_CODE;
      case (aluop)
         ALUOP_ADD: d.op = OP_ADD;
         ALUOP_SUB: d.op = OP_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_XOR: d.op = OP_XOR;
               FUNCT_ADD: d.op = OP_ADD;
               FUNCT_SUB: d.op = OP_SUB;
               FUNCT_MOD: d.op = OP_MOD;
               default:   d.illegal = 1'b1;
            endcase
         end
         default: begin
            case (opcode)
               OPC_SLTI: d.op = OP_SLTI;
               OPC_ADDI: d.op = OP_ADDI;
               OPC_ORI:  d.op = OP_ORI;
               OPC_ANDI: d.op = OP_ANDI;
               default:  d.illegal = 1'b1;
            endcase
         end
      endcase
      if (d.illegal) d.op = NOP_CODE;
      return d;
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control table with width extension; shared with the legacy path.
module alu_ctrl_decode
   import alu_pkg::*;
#(
   parameter int unsigned          OPC_W    = 3,
   parameter int unsigned          FUNCT_W  = 4,
   parameter int unsigned          OP_W     = 4,
   parameter logic [OP_W-1:0]      NOP_CODE = OP_W'(alu_pkg::NOP_CODE)
) (
   input  logic [ALUOP_W-1:0] aluop_i,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic [OPC_W-1:0]   opcode_i,
   output logic [OP_W-1:0]    op_o,
   output logic               illegal_o
);

   dec_t base_c;
   logic ext_bad_c;

   // Upper bits of a widened field only matter when that field selects the op.
   always_comb begin
      base_c    = alu_decode(aluop_i, funct_i[FUNCT_B_W-1:0], opcode_i[OPC_B_W-1:0]);
      ext_bad_c = 1'b0;
      if (aluop_i == ALUOP_RTYPE) ext_bad_c = ((funct_i >> FUNCT_B_W) != '0);
      if (aluop_i == ALUOP_ITYPE) ext_bad_c = ((opcode_i >> OPC_B_W) != '0);
      illegal_o = base_c.illegal | ext_bad_c;
      op_o      = illegal_o ? NOP_CODE : OP_W'(base_c.op);
   end

endmodule

// File: rtl/alu_control_seq.sv
// Registered valid/ready ALU control decoder; MOD ops are held in WAIT for
// MC_CYCLES extra cycles before being presented to the ALU.
module alu_control_seq
   import alu_pkg::*;
#(
   parameter int unsigned     OPC_W     = 3,
   parameter int unsigned     FUNCT_W   = 4,
   parameter int unsigned     OP_W      = 4,
   parameter int unsigned     MC_CYCLES = 3,
   parameter logic [OP_W-1:0] NOP_CODE  = OP_W'(alu_pkg::NOP_CODE)
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ALUOP_W-1:0] ALUOp,
   input  logic [FUNCT_W-1:0] Funct,
   input  logic [OPC_W-1:0]   opcode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OP_W-1:0]    Operacioni,
   output logic               illegal,
   output logic               busy
);

   localparam int unsigned        CNT_W    = (MC_CYCLES > 0) ? $clog2(MC_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0]   CNT_LOAD = (MC_CYCLES > 0) ? CNT_W'(MC_CYCLES - 1) : '0;
   localparam logic [OP_W-1:0]    MOD_CODE = OP_W'(OP_MOD);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic             ill_q, ill_d;
   logic             out_valid_q;
   logic             busy_q;

   logic [OP_W-1:0]  dec_op_c;
   logic             dec_ill_c;
   logic             accept_c;
   logic             enter_wait_c;

   alu_ctrl_decode #(
      .OPC_W    (OPC_W),
      .FUNCT_W  (FUNCT_W),
      .OP_W     (OP_W),
      .NOP_CODE (NOP_CODE)
   ) u_decode (
      .aluop_i   (ALUOp),
      .funct_i   (Funct),
      .opcode_i  (opcode),
      .op_o      (dec_op_c),
      .illegal_o (dec_ill_c)
   );

   assign in_ready     = (state_q == IDLE) | ((state_q == VALID) & out_ready);
   assign accept_c     = in_valid & in_ready;
   assign enter_wait_c = (MC_CYCLES > 0) & ~dec_ill_c & (dec_op_c == MOD_CODE);

   // Next-state: hold/drain transitions first, then a fresh accept overrides.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      ill_d   = ill_q;

      case (state_q)
         WAIT: begin
            if (cnt_q == '0) state_d = VALID;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         VALID: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = state_q;
      endcase

      if (accept_c) begin
         op_d  = dec_op_c;
         ill_d = dec_ill_c;
         if (enter_wait_c) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
         end else begin
            state_d = VALID;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= NOP_CODE;
         ill_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         ill_q       <= ill_d;
         out_valid_q <= (state_d == VALID);
         busy_q      <= (state_d == WAIT);
      end
   end

   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign Operacioni = op_q;
   assign illegal    = ill_q;

endmodule
